// File: rtl/csa_accumulator_pkg.sv
// Shared default widths and the operand extension rule used by the
// carry-save accumulator and its testbench-facing parameters.
package csa_accumulator_pkg;

  localparam int NN_DEFAULT = 16;
  localparam int AW_DEFAULT = 24;
  localparam int CW_DEFAULT = 8;
  localparam int EXT_MAX    = 64;

  // Bits at or above nn copy the operand MSB when sign_ext is set, else zero.
  function automatic logic [EXT_MAX-1:0] extend_operand(
    input logic [EXT_MAX-1:0] op,
    input int                 nn,
    input bit                 sign_ext
  );
    logic [EXT_MAX-1:0] res;
    logic               fill;
    fill = sign_ext & op[nn-1];
    for (int i = 0; i < EXT_MAX; i++) begin
      res[i] = (i < nn) ? op[i] : fill;
    end
    return res;
  endfunction

endpackage

// File: rtl/csa_compress42.sv
// 4:2 carry-save compressor built from two 3:2 layers; the carry vector is
// already shifted into place and truncated to W bits.
module csa_compress42 #(
  parameter int W = 24
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  logic [W-1:0] s1;
  logic [W-1:0] c1;

  // Carries out of bit W-1 fall off the top, keeping sum_o + carry_o equal
  // to a+b+c+d modulo 2^W.
  always_comb begin
    s1 = a_i ^ b_i ^ c_i;
    c1 = '0;
    for (int i = 1; i < W; i++) begin
      c1[i] = (a_i[i-1] & b_i[i-1]) | (a_i[i-1] & c_i[i-1]) | (b_i[i-1] & c_i[i-1]);
    end
    sum_o   = s1 ^ c1 ^ d_i;
    carry_o = '0;
    for (int i = 1; i < W; i++) begin
      carry_o[i] = (s1[i-1] & c1[i-1]) | (s1[i-1] & d_i[i-1]) | (c1[i-1] & d_i[i-1]);
    end
  end

endmodule

// File: rtl/csa_accumulator.sv
// Four-operand carry-save accumulator: stage 1 compresses each beat, stage 2
// folds it into a redundant accumulator and resolves the sum on the last beat.
module csa_accumulator
  import csa_accumulator_pkg::*;
#(
  parameter int NN     = NN_DEFAULT,
  parameter int AW     = AW_DEFAULT,
  parameter int CW     = CW_DEFAULT,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [NN-1:0] in_a,
  input  logic [NN-1:0] in_b,
  input  logic [NN-1:0] in_c,
  input  logic [NN-1:0] in_d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [CW-1:0] out_count
);

  localparam bit SIGN_EXT = (SIGNED != 0);

  logic          en;
  logic [AW-1:0] ext_a, ext_b, ext_c, ext_d;
  logic [AW-1:0] st1_sum, st1_carry;
  logic [AW-1:0] st2_sum, st2_carry;
  logic [CW-1:0] cnt_inc;

  logic [AW-1:0] s1_s_q, s1_s_d;
  logic [AW-1:0] s1_c_q, s1_c_d;
  logic          s1_v_q, s1_v_d;
  logic          s1_last_q, s1_last_d;
  logic [AW-1:0] acc_s_q, acc_s_d;
  logic [AW-1:0] acc_c_q, acc_c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_sum_q, out_sum_d;
  logic [CW-1:0] out_count_q, out_count_d;

  assign en = (!out_valid_q || out_ready) && !clr;

  assign ext_a = AW'(extend_operand(EXT_MAX'(in_a), NN, SIGN_EXT));
  assign ext_b = AW'(extend_operand(EXT_MAX'(in_b), NN, SIGN_EXT));
  assign ext_c = AW'(extend_operand(EXT_MAX'(in_c), NN, SIGN_EXT));
  assign ext_d = AW'(extend_operand(EXT_MAX'(in_d), NN, SIGN_EXT));

  csa_compress42 #(.W(AW)) u_stage1 (
    .a_i     (ext_a),
    .b_i     (ext_b),
    .c_i     (ext_c),
    .d_i     (ext_d),
    .sum_o   (st1_sum),
    .carry_o (st1_carry)
  );

  csa_compress42 #(.W(AW)) u_stage2 (
    .a_i     (s1_s_q),
    .b_i     (s1_c_q),
    .c_i     (acc_s_q),
    .d_i     (acc_c_q),
    .sum_o   (st2_sum),
    .carry_o (st2_carry)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  // The last beat resolves through the same compressor as ordinary beats, so
  // a single carry-propagate adder sits only in front of out_sum.
  always_comb begin
    s1_s_d      = s1_s_q;
    s1_c_d      = s1_c_q;
    s1_v_d      = s1_v_q;
    s1_last_d   = s1_last_q;
    acc_s_d     = acc_s_q;
    acc_c_d     = acc_c_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;

    if (en) begin
      s1_s_d    = st1_sum;
      s1_c_d    = st1_carry;
      s1_v_d    = in_valid;
      s1_last_d = in_last;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (en && s1_v_q) begin
      if (s1_last_q) begin
        out_sum_d   = st2_sum + st2_carry;
        out_count_d = cnt_inc;
        out_valid_d = 1'b1;
        acc_s_d     = '0;
        acc_c_d     = '0;
        cnt_d       = '0;
      end else begin
        acc_s_d = st2_sum;
        acc_c_d = st2_carry;
        cnt_d   = cnt_inc;
      end
    end

    if (clr) begin
      s1_v_d      = 1'b0;
      acc_s_d     = '0;
      acc_c_d     = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_s_q      <= '0;
      s1_c_q      <= '0;
      s1_v_q      <= 1'b0;
      s1_last_q   <= 1'b0;
      acc_s_q     <= '0;
      acc_c_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      s1_s_q      <= s1_s_d;
      s1_c_q      <= s1_c_d;
      s1_v_q      <= s1_v_d;
      s1_last_q   <= s1_last_d;
      acc_s_q     <= acc_s_d;
      acc_c_q     <= acc_c_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Testbench for csa_accumulator: table-driven packets, directed clear,
// backpressure and reset sequences, then a randomized run against a model.
module tb_csa_accumulator;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        in_last;
  logic [15:0] in_a, in_b, in_c, in_d;
  logic        out_ready;

  logic        u_in_ready, u_out_valid;
  logic [23:0] u_out_sum;
  logic [7:0]  u_out_count;
  logic        s_in_ready, s_out_valid;
  logic [23:0] s_out_sum;
  logic [7:0]  s_out_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a, b, c, d;
    int          beats;
    logic [23:0] expU;
    logic [23:0] expS;
    logic [7:0]  expCnt;
  } vec_t;

  typedef struct {
    logic [23:0] sum;
    logic [7:0]  cnt;
  } res_t;

  localparam int NVEC = 7;
  vec_t vecs[NVEC];
  res_t uq[$];
  res_t sq[$];

  csa_accumulator #(.NN(16), .AW(24), .CW(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(u_in_ready), .in_last(in_last),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(u_out_valid), .out_ready(out_ready),
    .out_sum(u_out_sum), .out_count(u_out_count)
  );

  csa_accumulator #(.NN(16), .AW(24), .CW(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_last(in_last),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_sum(s_out_sum), .out_count(s_out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic last,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] d);
    in_valid = v;
    in_last  = last;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    in_d     = d;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResult(input string tag, input logic [23:0] expU,
                             input logic [23:0] expS, input logic [7:0] expCnt);
    checkOutput({tag, "_valid_u"}, 32'(u_out_valid), 32'd1);
    checkOutput({tag, "_valid_s"}, 32'(s_out_valid), 32'd1);
    checkOutput({tag, "_sum_u"},   32'(u_out_sum),   32'(expU));
    checkOutput({tag, "_sum_s"},   32'(s_out_sum),   32'(expS));
    checkOutput({tag, "_cnt_u"},   32'(u_out_count), 32'(expCnt));
    checkOutput({tag, "_cnt_s"},   32'(s_out_count), 32'(expCnt));
  endtask

  initial begin
    logic        uStall;
    logic [23:0] holdU, holdS;
    logic [7:0]  holdCnt;
    longint      uacc, sacc;
    int          nbeats;
    res_t        r;

    vecs[0] = '{16'd1,    16'd2,    16'd3,    16'd4,    1,   24'h00000A, 24'h00000A, 8'd1};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3,   24'h0BFFF4, 24'hFFFFF4, 8'd3};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1,   24'h03FFFC, 24'hFFFFFC, 8'd1};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 65,  24'h03FEFC, 24'hFFFEFC, 8'd65};
    vecs[4] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000, 1,   24'h010000, 24'hFF0000, 8'd1};
    vecs[5] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 2,   24'h03FFF8, 24'h03FFF8, 8'd2};
    vecs[6] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 300, 24'h00012C, 24'h00012C, 8'd255};

    rst       = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_valid", 32'(u_out_valid), 32'd0);
    checkOutput("reset_sum",   32'(u_out_sum),   32'd0);
    checkOutput("reset_count", 32'(u_out_count), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("release_in_ready", 32'(u_in_ready), 32'd1);
    out_ready = 1'b1;
    tick();

    // Each table packet: one beat per cycle, result two edges after the last beat is presented.
    for (int v = 0; v < NVEC; v++) begin
      for (int i = 0; i < vecs[v].beats; i++) begin
        applyStimulus(1'b1, i == vecs[v].beats - 1, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d);
        tick();
      end
      applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
      checkOutput($sformatf("vec%0d_early", v), 32'(u_out_valid), 32'd0);
      tick();
      checkResult($sformatf("vec%0d", v), vecs[v].expU, vecs[v].expS, vecs[v].expCnt);
    end

    // Clear discards a partial packet and refuses the beat offered alongside it.
    tick();
    applyStimulus(1'b1, 1'b0, 16'd7, 16'd0, 16'd0, 16'd0);
    tick();
    tick();
    clr = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'd9, 16'd0, 16'd0, 16'd0);
    #1;
    checkOutput("clr_in_ready", 32'(u_in_ready), 32'd0);
    tick();
    clr = 1'b0;
    applyStimulus(1'b1, 1'b1, 16'd5, 16'd0, 16'd0, 16'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    checkOutput("clr_no_result", 32'(u_out_valid), 32'd0);
    tick();
    checkResult("clr_after", 24'd5, 24'd5, 8'd1);

    // Backpressure: a pending result freezes the pipeline until consumed.
    tick();
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 16'd3, 16'd3, 16'd3, 16'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    tick();
    checkResult("bp_first", 24'd12, 24'd12, 8'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("bp_in_ready%0d", i), 32'(u_in_ready), 32'd0);
      checkOutput($sformatf("bp_valid%0d", i),    32'(u_out_valid), 32'd1);
      checkOutput($sformatf("bp_sum%0d", i),      32'(u_out_sum),   32'd12);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("bp_handoff", 32'(u_out_valid), 32'd0);

    // Reset mid-accumulation zeroes outputs at once and drops the partial sum.
    applyStimulus(1'b1, 1'b0, 16'd1, 16'd1, 16'd1, 16'd1);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_valid", 32'(u_out_valid), 32'd0);
    checkOutput("rst_mid_sum",   32'(u_out_sum),   32'd0);
    checkOutput("rst_mid_count", 32'(u_out_count), 32'd0);
    checkOutput("rst_mid_sum_s", 32'(s_out_sum),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 16'd4, 16'd0, 16'd0, 16'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    tick();
    checkResult("rst_after", 24'd4, 24'd4, 8'd1);

    // Randomized traffic against a packet-level model of accepted beats.
    uStall  = 1'b0;
    holdU   = '0;
    holdS   = '0;
    holdCnt = '0;
    uacc    = 0;
    sacc    = 0;
    nbeats  = 0;
    tick();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc >= 580) begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end else begin
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 6);
      end
      in_last = ($urandom_range(0, 3) == 0);
      in_a    = 16'($urandom);
      in_b    = 16'($urandom);
      in_c    = 16'($urandom);
      in_d    = 16'($urandom);
      #1;
      checkOutput("rnd_in_ready", 32'(u_in_ready), 32'(!u_out_valid || out_ready));
      if (uStall) begin
        checkOutput("rnd_hold_valid", 32'(u_out_valid), 32'd1);
        checkOutput("rnd_hold_sum_u", 32'(u_out_sum),   32'(holdU));
        checkOutput("rnd_hold_sum_s", 32'(s_out_sum),   32'(holdS));
        checkOutput("rnd_hold_cnt",   32'(u_out_count), 32'(holdCnt));
      end
      if (u_out_valid && out_ready) begin
        if (uq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL rnd_unexpected_u: got result 0x%0h, expected none", u_out_sum);
        end else begin
          r = uq.pop_front();
          checkOutput("rnd_sum_u", 32'(u_out_sum),   32'(r.sum));
          checkOutput("rnd_cnt_u", 32'(u_out_count), 32'(r.cnt));
        end
      end
      if (s_out_valid && out_ready) begin
        if (sq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL rnd_unexpected_s: got result 0x%0h, expected none", s_out_sum);
        end else begin
          r = sq.pop_front();
          checkOutput("rnd_sum_s", 32'(s_out_sum),   32'(r.sum));
          checkOutput("rnd_cnt_s", 32'(s_out_count), 32'(r.cnt));
        end
      end
      uStall  = u_out_valid && !out_ready;
      holdU   = u_out_sum;
      holdS   = s_out_sum;
      holdCnt = u_out_count;
      if (in_valid && u_in_ready) begin
        uacc = uacc + longint'(in_a) + longint'(in_b) + longint'(in_c) + longint'(in_d);
        sacc = sacc + longint'($signed(in_a)) + longint'($signed(in_b))
                    + longint'($signed(in_c)) + longint'($signed(in_d));
        nbeats++;
        if (in_last) begin
          r.cnt = (nbeats > 255) ? 8'd255 : 8'(nbeats);
          r.sum = uacc[23:0];
          uq.push_back(r);
          r.sum = sacc[23:0];
          sq.push_back(r);
          uacc   = 0;
          sacc   = 0;
          nbeats = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    checkOutput("rnd_drain_u", 32'(uq.size()), 32'd0);
    checkOutput("rnd_drain_s", 32'(sq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
